deint_ctrl: RTL

DEINT_CTRL -- requirements
Module: deint_ctrl

---
 rtl/deint_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/deint_ctrl.sv
// deint_ctrl: address/strobe controller for a block deinterleaver.
// A frame is written row-major into RAM (base + wcnt), held for one TURN cycle,
// then read back column-major (16 columns, m_len/16 rows).
`timescale 1ns/1ps
module deint_ctrl (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [4:0]  link_id,
  input  logic        din_vld,
  input  logic        rd_req,
  input  logic        flush,
  output logic        ram_wen,
  output logic [15:0] ram_waddr,
  output logic        ram_ren,
  output logic [15:0] ram_raddr,
  output logic        dout_vld,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_TURN  = 2'd2,
    S_READ  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] m_len_q, m_len_d;
  logic [15:0] base_q, base_d;
  logic [8:0]  rows_q, rows_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [8:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic        ram_wen_q, ram_wen_d;
  logic [15:0] ram_waddr_q, ram_waddr_d;
  logic        ram_ren_q, ram_ren_d;
  logic [15:0] ram_raddr_q, ram_raddr_d;
  logic        dout_vld_q;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Link table lookup: frame length, RAM base, and rows (= length / 16).
  logic        lut_ok;
  logic [15:0] lut_len;
  logic [15:0] lut_base;
  logic [8:0]  lut_rows;

  // Decode link_id into frame geometry; unsupported ids flag lut_ok=0.
  always_comb begin
    lut_ok   = 1'b1;
    lut_len  = 16'd0;
    lut_base = 16'h0000;
    lut_rows = 9'd0;
    case (link_id)
      5'd5:    begin lut_len = 16'd288;  lut_base = 16'h0000; lut_rows = 9'd18;  end
      5'd6:    begin lut_len = 16'd672;  lut_base = 16'h0120; lut_rows = 9'd42;  end
      5'd7:    begin lut_len = 16'd1056; lut_base = 16'h03C0; lut_rows = 9'd66;  end
      5'd11:   begin lut_len = 16'd432;  lut_base = 16'h07E0; lut_rows = 9'd27;  end
      5'd17:   begin lut_len = 16'd1872; lut_base = 16'h0990; lut_rows = 9'd117; end
      5'd19:   begin lut_len = 16'd5616; lut_base = 16'h10E0; lut_rows = 9'd351; end
      default: lut_ok = 1'b0;
    endcase
  end

  // Qualified events. flush masks every event so it always wins.
  logic start_ok, start_bad, wr_fire, wr_last, rd_fire, rd_last;
  assign start_ok  = (state_q == S_IDLE) && start && !flush && lut_ok;
  assign start_bad = (state_q == S_IDLE) && start && !flush && !lut_ok;
  assign wr_fire   = (state_q == S_WRITE) && din_vld && !flush;
  assign wr_last   = wr_fire && (wcnt_q == (m_len_q - 16'd1));
  assign rd_fire   = (state_q == S_READ) && rd_req && !flush;
  assign rd_last   = rd_fire && (row_q == (rows_q - 9'd1)) && (col_q == 4'hF);

  // State and datapath registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      m_len_q     <= 16'd0;
      base_q      <= 16'd0;
      rows_q      <= 9'd0;
      wcnt_q      <= 16'd0;
      row_q       <= 9'd0;
      col_q       <= 4'd0;
      ram_wen_q   <= 1'b0;
      ram_waddr_q <= 16'd0;
      ram_ren_q   <= 1'b0;
      ram_raddr_q <= 16'd0;
      dout_vld_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_len_q     <= m_len_d;
      base_q      <= base_d;
      rows_q      <= rows_d;
      wcnt_q      <= wcnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      ram_wen_q   <= ram_wen_d;
      ram_waddr_q <= ram_waddr_d;
      ram_ren_q   <= ram_ren_d;
      ram_raddr_q <= ram_raddr_d;
      dout_vld_q  <= ram_ren_q;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: IDLE -> WRITE -> TURN (one cycle) -> READ -> IDLE.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_ok) state_d = S_WRITE;
        S_WRITE: if (wr_last)  state_d = S_TURN;
        S_TURN:  state_d = S_READ;
        S_READ:  if (rd_last)  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output/datapath next values: strobes, addresses, counters, latched geometry.
  always_comb begin
    m_len_d     = m_len_q;
    base_d      = base_q;
    rows_d      = rows_q;
    wcnt_d      = wcnt_q;
    row_d       = row_q;
    col_d       = col_q;
    ram_wen_d   = wr_fire;
    ram_waddr_d = ram_waddr_q;
    ram_ren_d   = rd_fire;
    ram_raddr_d = ram_raddr_q;
    done_d      = rd_last;
    err_d       = start_bad;

    if (start_ok) begin
      m_len_d = lut_len;
      base_d  = lut_base;
      rows_d  = lut_rows;
      wcnt_d  = 16'd0;
      row_d   = 9'd0;
      col_d   = 4'd0;
    end

    if (wr_fire) begin
      ram_waddr_d = base_q + wcnt_q;
      wcnt_d      = wr_last ? 16'd0 : (wcnt_q + 16'd1);
    end

    // Column-major read: row*16 is a plain shift of the row counter.
    if (rd_fire) begin
      ram_raddr_d = base_q + {3'b000, row_q, 4'b0000} + {12'd0, col_q};
      if (rd_last) begin
        row_d = 9'd0;
        col_d = 4'd0;
      end else if (row_q == (rows_q - 9'd1)) begin
        row_d = 9'd0;
        col_d = col_q + 4'd1;
      end else begin
        row_d = row_q + 9'd1;
      end
    end

    if (flush) begin
      wcnt_d = 16'd0;
      row_d  = 9'd0;
      col_d  = 4'd0;
    end
  end

  assign ram_wen   = ram_wen_q;
  assign ram_waddr = ram_waddr_q;
  assign ram_ren   = ram_ren_q;
  assign ram_raddr = ram_raddr_q;
  assign dout_vld  = dout_vld_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule
